avalon_bram_burst: RTL and testbench
====================================

# avalon_bram_burst

Parametrised Avalon-MM agent block RAM, the successor of the fixed 32-bit BRAM agent used behind the memory controller. Data width, depth and maximum burst length are parameters, and the block adds pipelined back-to-back single reads, a selectable wrapping-burst mode, and defined behaviour for degenerate commands. It sits on an Avalon-MM host port (CPU or DMA) as a zero-wait-state local memory.

## Interface

- DATA_W, 32, data width in bits; multiple of 8, at least 8.
- RAM_ADD_W, 11, word-address width; depth is 2**RAM_ADD_W words.
- BURSTCOUNT_W, 4, burstcount width; maximum burst is 2**(BURSTCOUNT_W-1) beats.
- WRAP_BURST, 0, selects burst addressing: 0 = linear, 1 = wrapping.
- Derived: BE_W = DATA_W/8; ADDR_W = RAM_ADD_W + clog2(BE_W).

Ports:

- clk  in  1  clock; everything is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  ADDR_W  byte address. Word address = address[ADDR_W-1:clog2(BE_W)]; low bits are ignored.
- read  in  1  read request.
- write  in  1  write request or write beat.
- writedata  in  DATA_W  write data.
- byteenable  in  BE_W  per-byte write enable; bit i covers writedata[8i+7:8i].
- burstcount  in  BURSTCOUNT_W  burst length in beats; 0 is treated as 1.
- readdata  out  DATA_W  registered read data; holds its last value when not valid.
- readdatavalid  out  1  registered; marks one read beat.
- waitrequest  out  1  registered; when high, read and write are ignored (except write beats in WR_BURST).

## Operation

- **Storage:** BE_W byte lanes, each 2**RAM_ADD_W x 8 (infers BRAM with byte enables). Contents are not reset.
- **Acceptance:** a command is accepted on an edge where waitrequest=0, the block is in IDLE, and read or write is high.
- **Read and write together in IDLE:** write wins and read is dropped.
- **States:**
  - RESET: entered during reset.
  - IDLE: commands accepted here.
  - RD_BURST: read beats remaining.
  - WR_BURST: write beats remaining.
- **RESET → IDLE:** on the first edge after reset deasserts.
- **IDLE, read accepted:**
  - The word at the command address is registered into readdata and readdatavalid is set to 1.
  - Base address and burstcount are latched; beat counter = 1.
  - B = max(burstcount,1). If B = 1, stay in IDLE; otherwise go to RD_BURST.
- **RD_BURST:** every edge reads beat[counter] and sets readdatavalid=1, then increments the counter. After the beat with counter = B-1 is read, return to IDLE.
- **IDLE, write accepted:**
  - Write the enabled bytes at the command address.
  - If B > 1, latch base and B, set counter = 1, and go to WR_BURST.
- **WR_BURST:**
  - Each edge with write=1 writes beat[counter] and increments the counter. Edges with write=0 are stalls: no write, no state change.
  - After the beat with counter = B-1, return to IDLE.
  - read is ignored in this state.
- **Beat address (word units, modulo 2**RAM_ADD_W):**
  - Linear: base + counter.
  - Wrapping (WRAP_BURST=1, B a power of two): (base & ~(B-1)) | ((base + counter) & (B-1)).
  - Wrapping with B not a power of two: falls back to linear.
- **Address overflow:** the top of memory wraps to word 0 in both modes.
- **Oversize bursts:** burstcount values above the maximum are not clamped; the block performs B beats.
- **Reset mid-burst:** the burst is abandoned. Memory writes already done remain; no further beats are produced.

## Timing

- **Reset values:** readdata = 0, readdatavalid = 0, waitrequest = 1. waitrequest falls 1 cycle after reset deasserts.
- **Read latency:** 1 cycle. For a command accepted at edge N, beats appear with readdatavalid=1 after edges N through N+B-1, on consecutive cycles with no gaps.
- **waitrequest:**
  - Equals 1 exactly while in RESET or RD_BURST.
  - In RD_BURST it is high for B-1 cycles after acceptance, so the next command can be accepted at edge N+B.
  - It is 0 in WR_BURST, so write beats are not back-pressured.
- **Single-beat reads:** one per cycle sustained, with continuous readdatavalid.
- **Write timing:** data lands in memory at the accepting edge. A read of the same word accepted on the next edge returns the new data.
- **readdatavalid:** deasserts on the edge after the last beat unless a new read is accepted on that edge.

## Test plan

- **Reset:** assert reset mid-cycle → waitrequest=1, readdatavalid=0, readdata=0 immediately. Release → waitrequest=0 after 1 edge.
- **Byte enables:** write 0xDEADBEEF at byte address 0x10 with byteenable=1111, then write 0x00000011 with byteenable=0001, then read → readdata=0xDEADBE11 one cycle after acceptance.
- **Linear bursts:** 4-beat write burst at 0x20 with data 1..4, inserting a write=0 stall after beat 2. Then a 4-beat read at 0x20 → readdata 1,2,3,4 on 4 consecutive cycles, waitrequest high for exactly 3 cycles.
- **Wrapping burst:** with WRAP_BURST=1, a 4-beat read at word 6 → words 6,7,4,5. Same stimulus with WRAP_BURST=0 → words 6,7,8,9.
- **Edge cases:**
  - Read at the last word with B=2 → last word, then word 0.
  - burstcount=0 → exactly one beat.
  - read and write both high in IDLE → write performed, no readdatavalid.
- **Throughput and abort:**
  - Back-to-back single reads for 8 cycles → readdatavalid high for 8 consecutive cycles.
  - Reset asserted during beat 2 of a 4-beat read → no further readdatavalid.

Source files
------------

// File: rtl/avalon_bram_burst.sv
// Avalon-MM agent block RAM: byte-lane storage, 1-cycle registered reads,
// pipelined single reads and linear or wrapping bursts.
module avalon_bram_burst #(
  parameter int DATA_W       = 32,
  parameter int RAM_ADD_W    = 11,
  parameter int BURSTCOUNT_W = 4,
  parameter int WRAP_BURST   = 0,
  localparam int BE_W        = DATA_W / 8,
  localparam int BYTE_OFF    = $clog2(BE_W),
  localparam int ADDR_W      = RAM_ADD_W + BYTE_OFF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       address,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_W-1:0]       writedata,
  input  logic [BE_W-1:0]         byteenable,
  input  logic [BURSTCOUNT_W-1:0] burstcount,
  output logic [DATA_W-1:0]       readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest
);

  localparam int DEPTH = 2 ** RAM_ADD_W;

  typedef enum logic [1:0] {ST_RESET, ST_IDLE, ST_RD_BURST, ST_WR_BURST} state_t;

  state_t                  state_q, state_d;
  logic [RAM_ADD_W-1:0]    base_q, base_d;
  logic [BURSTCOUNT_W-1:0] blen_q, blen_d;
  logic [BURSTCOUNT_W-1:0] cnt_q, cnt_d;
  logic                    readdatavalid_q, readdatavalid_d;
  logic                    waitrequest_q, waitrequest_d;

  logic [RAM_ADD_W-1:0]    cmd_word, beat_addr, rd_addr, wr_addr, wrap_mask;
  logic [BURSTCOUNT_W-1:0] cmd_blen;
  logic                    blen_pow2, last_beat, rd_en, wr_en;

  assign cmd_word  = address[ADDR_W-1:BYTE_OFF];
  assign cmd_blen  = (burstcount == '0) ? BURSTCOUNT_W'(1) : burstcount;
  assign blen_pow2 = ((blen_q & (blen_q - BURSTCOUNT_W'(1))) == '0);
  assign wrap_mask = RAM_ADD_W'(blen_q - BURSTCOUNT_W'(1));
  assign last_beat = (cnt_q == (blen_q - BURSTCOUNT_W'(1)));

  // Address arithmetic is naturally modulo the depth, so the top word rolls to 0.
  always_comb begin
    beat_addr = base_q + RAM_ADD_W'(cnt_q);
    if ((WRAP_BURST != 0) && blen_pow2)
      beat_addr = (base_q & ~wrap_mask) | (beat_addr & wrap_mask);
  end

  always_comb begin
    state_d         = state_q;
    base_d          = base_q;
    blen_d          = blen_q;
    cnt_d           = cnt_q;
    rd_en           = 1'b0;
    rd_addr         = cmd_word;
    wr_en           = 1'b0;
    wr_addr         = cmd_word;
    readdatavalid_d = 1'b0;

    case (state_q)
      ST_RESET: state_d = ST_IDLE;

      ST_IDLE: begin
        if (!waitrequest_q) begin
          if (write) begin
            wr_en = 1'b1;
            if (cmd_blen > BURSTCOUNT_W'(1)) begin
              base_d  = cmd_word;
              blen_d  = cmd_blen;
              cnt_d   = BURSTCOUNT_W'(1);
              state_d = ST_WR_BURST;
            end
          end else if (read) begin
            rd_en           = 1'b1;
            readdatavalid_d = 1'b1;
            base_d          = cmd_word;
            blen_d          = cmd_blen;
            cnt_d           = BURSTCOUNT_W'(1);
            if (cmd_blen > BURSTCOUNT_W'(1))
              state_d = ST_RD_BURST;
          end
        end
      end

      ST_RD_BURST: begin
        rd_en           = 1'b1;
        rd_addr         = beat_addr;
        readdatavalid_d = 1'b1;
        cnt_d           = cnt_q + BURSTCOUNT_W'(1);
        if (last_beat)
          state_d = ST_IDLE;
      end

      ST_WR_BURST: begin
        // write=0 is a host stall: hold position until the next beat arrives.
        if (write) begin
          wr_en   = 1'b1;
          wr_addr = beat_addr;
          cnt_d   = cnt_q + BURSTCOUNT_W'(1);
          if (last_beat)
            state_d = ST_IDLE;
        end
      end

      default: state_d = ST_RESET;
    endcase

    waitrequest_d = (state_d == ST_RESET) || (state_d == ST_RD_BURST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_RESET;
      base_q          <= '0;
      blen_q          <= '0;
      cnt_q           <= '0;
      readdatavalid_q <= 1'b0;
      waitrequest_q   <= 1'b1;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      blen_q          <= blen_d;
      cnt_q           <= cnt_d;
      readdatavalid_q <= readdatavalid_d;
      waitrequest_q   <= waitrequest_d;
    end
  end

  assign readdatavalid = readdatavalid_q;
  assign waitrequest   = waitrequest_q;

  // One 8-bit-wide RAM per byte lane so byteenable maps onto lane write enables.
  generate
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
      logic [7:0] mem [0:DEPTH-1];
      logic [7:0] rd_byte_q;

      always_ff @(posedge clk) begin
        if (wr_en && byteenable[gi])
          mem[wr_addr] <= writedata[gi*8 +: 8];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          rd_byte_q <= '0;
        else if (rd_en)
          rd_byte_q <= mem[rd_addr];
      end

      assign readdata[gi*8 +: 8] = rd_byte_q;
    end

    if (BYTE_OFF > 0) begin : g_addr_lsb
      logic addr_lsb_unused;
      assign addr_lsb_unused = ^address[BYTE_OFF-1:0];
    end
  endgenerate

endmodule

// File: tb/tb_avalon_bram_burst.sv
// Bench for avalon_bram_burst: linear and wrapping instances share one stimulus
// stream and are checked against per-mode memory models.
`timescale 1ns/1ps
module tb_avalon_bram_burst;

  localparam int DW    = 32;
  localparam int RAW   = 11;
  localparam int BCW   = 4;
  localparam int AW    = 13;
  localparam int DEPTH = 2048;

  typedef logic [DW-1:0] word_q_t[$];

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [AW-1:0]  address = '0;
  logic           read = 1'b0;
  logic           write = 1'b0;
  logic [DW-1:0]  writedata = '0;
  logic [3:0]     byteenable = '0;
  logic [BCW-1:0] burstcount = '0;

  logic [DW-1:0]  rd_l, rd_w;
  logic           rdv_l, rdv_w, wr_l, wr_w;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ref_lin [DEPTH];
  logic [DW-1:0] ref_wrp [DEPTH];

  always #5 clk = ~clk;

  avalon_bram_burst #(.DATA_W(DW), .RAM_ADD_W(RAW), .BURSTCOUNT_W(BCW), .WRAP_BURST(0)) dut_lin (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .burstcount(burstcount),
    .readdata(rd_l), .readdatavalid(rdv_l), .waitrequest(wr_l));

  avalon_bram_burst #(.DATA_W(DW), .RAM_ADD_W(RAW), .BURSTCOUNT_W(BCW), .WRAP_BURST(1)) dut_wrp (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .burstcount(burstcount),
    .readdata(rd_w), .readdatavalid(rdv_w), .waitrequest(wr_w));

  // Reference beat address: whole-block alignment plus offset within the block.
  function automatic int beat_word(int base, int k, int b, bit wrap);
    if (wrap && ((1 << $clog2(b)) == b))
      return (base / b) * b + ((base + k) % b);
    return (base + k) % DEPTH;
  endfunction

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] d, logic [3:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  function automatic word_q_t exp_beats(int w, int bc, bit wrap);
    word_q_t q;
    int b;
    b = (bc == 0) ? 1 : bc;
    for (int k = 0; k < b; k++)
      q.push_back(wrap ? ref_wrp[beat_word(w, k, b, 1'b1)] : ref_lin[beat_word(w, k, b, 1'b0)]);
    return q;
  endfunction

  // Bounded wait for both instances to accept commands.
  task automatic wait_ready();
    for (int t = 0; t < 50 && (wr_l || wr_w); t++) @(negedge clk);
    checks++;
    if (wr_l || wr_w) begin
      errors++;
      $display("FAIL wait_ready waitrequest=%0b/%0b required 0/0", wr_l, wr_w);
    end
  endtask

  task automatic drv_write(input int w, input int bc, input word_q_t data,
                           input logic [3:0] be, input int stall_at, output int wr_hi);
    int b;
    b = (bc == 0) ? 1 : bc;
    wait_ready();
    wr_hi = 0;
    for (int k = 0; k < b; k++) begin
      if (k == stall_at) begin
        write   = 1'b0;
        address = AW'($urandom);
        @(negedge clk);
      end
      if (k > 0 && (wr_l || wr_w)) wr_hi++;
      write      = 1'b1;
      read       = (k > 0) ? 1'($urandom) : 1'b0;
      address    = (k == 0) ? AW'(w * 4 + int'($urandom_range(0, 3))) : AW'($urandom);
      burstcount = (k == 0) ? BCW'(bc) : BCW'($urandom);
      writedata  = data[k];
      byteenable = be;
      ref_lin[beat_word(w, k, b, 1'b0)] = merge(ref_lin[beat_word(w, k, b, 1'b0)], data[k], be);
      ref_wrp[beat_word(w, k, b, 1'b1)] = merge(ref_wrp[beat_word(w, k, b, 1'b1)], data[k], be);
      @(negedge clk);
    end
    write = 1'b0;
    read  = 1'b0;
  endtask

  task automatic drv_read(input int w, input int bc, output word_q_t ql, output word_q_t qw,
                          output int wr_hi, output logic [15:0] vpat);
    int b;
    b = (bc == 0) ? 1 : bc;
    wait_ready();
    ql = {};
    qw = {};
    wr_hi = 0;
    vpat = '0;
    read       = 1'b1;
    address    = AW'(w * 4 + int'($urandom_range(0, 3)));
    burstcount = BCW'(bc);
    byteenable = 4'($urandom);
    writedata  = DW'($urandom);
    @(negedge clk);
    read       = 1'b0;
    address    = AW'($urandom);
    burstcount = BCW'($urandom);
    for (int i = 0; i < b + 2; i++) begin
      if (rdv_l) ql.push_back(rd_l);
      if (rdv_w) qw.push_back(rd_w);
      if (i < 16) vpat[i] = rdv_l;
      if (wr_l) wr_hi++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_l !== 1'b1 || wr_w !== 1'b1) begin
      errors++; $display("FAIL reset_waitreq got %0b/%0b required 1/1", wr_l, wr_w);
    end
    checks++;
    if (rdv_l !== 1'b0 || rdv_w !== 1'b0) begin
      errors++; $display("FAIL reset_rdv got %0b/%0b required 0/0", rdv_l, rdv_w);
    end
    checks++;
    if (rd_l !== '0 || rd_w !== '0) begin
      errors++; $display("FAIL reset_readdata got %h/%h required 0", rd_l, rd_w);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (wr_l !== 1'b1) begin
      errors++; $display("FAIL release_waitreq_early got %0b required 1", wr_l);
    end
    @(negedge clk);
    checks++;
    if (wr_l !== 1'b0 || wr_w !== 1'b0) begin
      errors++; $display("FAIL release_waitreq got %0b/%0b required 0/0", wr_l, wr_w);
    end
  endtask

  task automatic test_fill();
    word_q_t d;
    int hi, tot;
    tot = 0;
    for (int blk = 0; blk < DEPTH / 8; blk++) begin
      d = {};
      for (int k = 0; k < 8; k++) d.push_back(DW'($urandom));
      drv_write(blk * 8, 8, d, 4'hF, (blk % 5 == 0) ? 3 : -1, hi);
      tot += hi;
    end
    checks++;
    if (tot != 0) begin
      errors++; $display("FAIL fill_waitreq high_cycles=%0d required 0", tot);
    end
  endtask

  task automatic test_byte_enables();
    word_q_t d, ql, qw;
    int hi;
    logic [15:0] vp;
    d = {32'hDEADBEEF};
    drv_write(4, 1, d, 4'b1111, -1, hi);
    d = {32'h00000011};
    drv_write(4, 1, d, 4'b0001, -1, hi);
    drv_read(4, 1, ql, qw, hi, vp);
    checks++;
    if (ql.size() != 1 || ql[0] !== 32'hDEADBE11 || vp !== 16'h0001) begin
      errors++; $display("FAIL byte_enable got %h beats=%0d required deadbe11 beats=1",
                         (ql.size() > 0) ? ql[0] : 32'h0, ql.size());
    end
  endtask

  task automatic test_linear_burst();
    word_q_t d, ql, qw;
    int hi;
    logic [15:0] vp;
    d = {32'd1, 32'd2, 32'd3, 32'd4};
    drv_write(8, 4, d, 4'hF, 2, hi);
    checks++;
    if (hi != 0) begin
      errors++; $display("FAIL wr_burst_waitreq high=%0d required 0", hi);
    end
    drv_read(8, 4, ql, qw, hi, vp);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ql.size() != 4 || ql[k] !== DW'(k + 1) || qw.size() != 4 || qw[k] !== DW'(k + 1)) begin
        errors++; $display("FAIL lin_burst beat%0d got %h/%h required %h", k,
                           (k < ql.size()) ? ql[k] : 32'h0, (k < qw.size()) ? qw[k] : 32'h0, k + 1);
      end
    end
    checks++;
    if (hi != 3) begin
      errors++; $display("FAIL lin_burst_waitreq high=%0d required 3", hi);
    end
    checks++;
    if (vp !== 16'h000F) begin
      errors++; $display("FAIL lin_burst_valid pattern=%h required 000f", vp);
    end
  endtask

  task automatic test_wrap_burst();
    word_q_t ql, qw;
    int hi;
    logic [15:0] vp;
    int lw[4];
    int ww[4];
    lw = '{6, 7, 8, 9};
    ww = '{6, 7, 4, 5};
    drv_read(6, 4, ql, qw, hi, vp);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ql.size() != 4 || qw.size() != 4 || ql[k] !== ref_lin[lw[k]] || qw[k] !== ref_wrp[ww[k]]) begin
        errors++; $display("FAIL wrap4 beat%0d got %h/%h required %h/%h", k,
                           (k < ql.size()) ? ql[k] : 32'h0, (k < qw.size()) ? qw[k] : 32'h0,
                           ref_lin[lw[k]], ref_wrp[ww[k]]);
      end
    end
    drv_read(6, 3, ql, qw, hi, vp);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (qw.size() != 3 || qw[k] !== ref_wrp[6 + k]) begin
        errors++; $display("FAIL wrap3_linear beat%0d got %h required %h", k,
                           (k < qw.size()) ? qw[k] : 32'h0, ref_wrp[6 + k]);
      end
    end
  endtask

  task automatic test_edge_cases();
    word_q_t ql, qw, el, ew;
    int hi, w, nv;
    logic [15:0] vp;
    logic [DW-1:0] dat;

    drv_read(DEPTH - 1, 2, ql, qw, hi, vp);
    checks++;
    if (ql.size() != 2 || ql[0] !== ref_lin[DEPTH - 1] || ql[1] !== ref_lin[0]) begin
      errors++; $display("FAIL top_wrap got %0d beats first=%h required %h then %h", ql.size(),
                         (ql.size() > 0) ? ql[0] : 32'h0, ref_lin[DEPTH - 1], ref_lin[0]);
    end
    ew = exp_beats(DEPTH - 1, 2, 1'b1);
    checks++;
    if (qw.size() != 2 || qw[0] !== ew[0] || qw[1] !== ew[1]) begin
      errors++; $display("FAIL top_wrap_wrapmode beats=%0d second=%h required %h", qw.size(),
                         (qw.size() > 1) ? qw[1] : 32'h0, ew[1]);
    end

    w = 300;
    drv_read(w, 0, ql, qw, hi, vp);
    checks++;
    if (ql.size() != 1 || ql[0] !== ref_lin[w] || hi != 0) begin
      errors++; $display("FAIL bc0 beats=%0d waitreq_high=%0d required 1 beat 0 high", ql.size(), hi);
    end

    w = 1500;
    drv_read(w, 12, ql, qw, hi, vp);
    el = exp_beats(w, 12, 1'b0);
    ew = exp_beats(w, 12, 1'b1);
    checks++;
    if (ql.size() != 12 || qw.size() != 12 || hi != 11) begin
      errors++; $display("FAIL oversize beats=%0d/%0d high=%0d required 12/12 11", ql.size(), qw.size(), hi);
    end else begin
      for (int k = 0; k < 12; k++) begin
        checks++;
        if (ql[k] !== el[k] || qw[k] !== ew[k]) begin
          errors++; $display("FAIL oversize beat%0d got %h/%h required %h/%h", k, ql[k], qw[k], el[k], ew[k]);
        end
      end
    end

    wait_ready();
    w = 777;
    dat = DW'($urandom);
    read = 1'b1; write = 1'b1; writedata = dat; byteenable = 4'hF;
    address = AW'(w * 4); burstcount = BCW'(1);
    ref_lin[w] = dat;
    ref_wrp[w] = dat;
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    nv = 0;
    for (int i = 0; i < 3; i++) begin
      if (rdv_l || rdv_w) nv++;
      @(negedge clk);
    end
    checks++;
    if (nv != 0) begin
      errors++; $display("FAIL rw_both valid_cycles=%0d required 0", nv);
    end
    drv_read(w, 1, ql, qw, hi, vp);
    checks++;
    if (ql.size() != 1 || ql[0] !== dat || qw.size() != 1 || qw[0] !== dat) begin
      errors++; $display("FAIL rw_both_written got %h required %h", (ql.size() > 0) ? ql[0] : 32'h0, dat);
    end
  endtask

  task automatic test_back_to_back();
    word_q_t d, ql, qw;
    int hi, w;
    logic [15:0] vp;
    logic [DW-1:0] dat;

    w = 42;
    dat = DW'($urandom);
    d = {dat};
    drv_write(w, 1, d, 4'hF, -1, hi);
    drv_read(w, 1, ql, qw, hi, vp);
    checks++;
    if (ql.size() != 1 || ql[0] !== dat) begin
      errors++; $display("FAIL write_then_read got %h required %h", (ql.size() > 0) ? ql[0] : 32'h0, dat);
    end

    wait_ready();
    for (int i = 0; i < 8; i++) begin
      w = $urandom_range(0, DEPTH - 1);
      read = 1'b1; address = AW'(w * 4); burstcount = BCW'(1);
      @(negedge clk);
      checks++;
      if (rdv_l !== 1'b1 || rdv_w !== 1'b1 || rd_l !== ref_lin[w] || rd_w !== ref_wrp[w]) begin
        errors++; $display("FAIL b2b_single%0d got v=%0b d=%h required v=1 d=%h", i, rdv_l, rd_l, ref_lin[w]);
      end
    end
    read = 1'b0;
    @(negedge clk);
    checks++;
    if (rdv_l !== 1'b0) begin
      errors++; $display("FAIL b2b_tail valid=%0b required 0", rdv_l);
    end
  endtask

  task automatic test_random();
    word_q_t d, ql, qw, el, ew;
    int hi, w, bc, b;
    logic [15:0] vp;
    for (int it = 0; it < 30; it++) begin
      w  = $urandom_range(0, DEPTH - 1);
      bc = $urandom_range(0, 15);
      b  = (bc == 0) ? 1 : bc;
      if ($urandom_range(0, 2) == 0) begin
        d = {};
        for (int k = 0; k < b; k++) d.push_back(DW'($urandom));
        drv_write(w, bc, d, 4'($urandom), $urandom_range(1, b), hi);
      end else begin
        drv_read(w, bc, ql, qw, hi, vp);
        el = exp_beats(w, bc, 1'b0);
        ew = exp_beats(w, bc, 1'b1);
        checks++;
        if (ql.size() != b || qw.size() != b || hi != b - 1) begin
          errors++; $display("FAIL rand%0d beats=%0d/%0d high=%0d required %0d/%0d %0d",
                             it, ql.size(), qw.size(), hi, b, b, b - 1);
        end else begin
          for (int k = 0; k < b; k++) begin
            checks++;
            if (ql[k] !== el[k] || qw[k] !== ew[k]) begin
              errors++; $display("FAIL rand%0d beat%0d got %h/%h required %h/%h",
                                 it, k, ql[k], qw[k], el[k], ew[k]);
            end
          end
        end
      end
    end
  endtask

  task automatic test_abort();
    word_q_t ql, qw;
    int hi, nv, w;
    logic [15:0] vp;
    w = 100;
    wait_ready();
    read = 1'b1; address = AW'(w * 4); burstcount = BCW'(4);
    @(negedge clk);
    read = 1'b0;
    @(negedge clk);
    checks++;
    if (rdv_l !== 1'b1 || rd_l !== ref_lin[w + 1]) begin
      errors++; $display("FAIL abort_beat2 got v=%0b d=%h required v=1 d=%h", rdv_l, rd_l, ref_lin[w + 1]);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (wr_l !== 1'b1 || rdv_l !== 1'b0 || rd_l !== '0 || rdv_w !== 1'b0 || rd_w !== '0) begin
      errors++; $display("FAIL midcycle_reset wr=%0b v=%0b d=%h required wr=1 v=0 d=0", wr_l, rdv_l, rd_l);
    end
    @(negedge clk);
    reset = 1'b0;
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rdv_l || rdv_w) nv++;
    end
    checks++;
    if (nv != 0) begin
      errors++; $display("FAIL abort_no_beats valid_cycles=%0d required 0", nv);
    end
    drv_read(w, 2, ql, qw, hi, vp);
    checks++;
    if (ql.size() != 2 || ql[0] !== ref_lin[w] || ql[1] !== ref_lin[w + 1]) begin
      errors++; $display("FAIL after_abort beats=%0d first=%h required 2 %h", ql.size(),
                         (ql.size() > 0) ? ql[0] : 32'h0, ref_lin[w]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_byte_enables();
    test_linear_burst();
    test_wrap_burst();
    test_edge_cases();
    test_back_to_back();
    test_random();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
